// File: rtl/instruction_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_sequencer : fetch/issue controller feeding instruction_decoder  |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module instruction_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int START_ADDR     = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           prog_len,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [31:0]           mem_data,
  input  logic                  mem_valid,
  output logic [31:0]           dec_data,
  output logic                  dec_dir,
  input  logic                  dec_ack,
  input  logic [31:0]           res_data,
  input  logic                  res_dor,
  output logic                  res_ack,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           retired,
  output logic [31:0]           last_result,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(START_ADDR);
  localparam int                    TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]         T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FETCH       = 3'd1,
    SEND        = 3'd2,
    WAIT_RESULT = 3'd3,
    ACK_RESULT  = 3'd4,
    NEXT        = 3'd5,
    DONE        = 3'd6,
    ERROR       = 3'd7
  } state_t;

  state_t        state, state_n;
  logic [15:0]   len;
  logic          halt_lat;
  logic [TW-1:0] timer;
  logic          load_run, take_instr, sent, capture, timeout, advance;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    load_run   = 1'b0;
    take_instr = 1'b0;
    sent       = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE, ERROR: if (start) begin
        load_run = 1'b1;
        state_n  = (prog_len == 16'd0) ? DONE : FETCH;
      end
      FETCH: if (mem_valid) begin
        take_instr = 1'b1;
        state_n    = SEND;
      end
      SEND: if (dec_ack) begin
        sent    = 1'b1;
        state_n = WAIT_RESULT;
      end
      // A result arriving on the expiry cycle still counts as success.
      WAIT_RESULT: if (res_dor) begin
        capture = 1'b1;
        state_n = ACK_RESULT;
      end else if (timer == T_LAST) begin
        timeout = 1'b1;
        state_n = ERROR;
      end
      ACK_RESULT: if (!res_dor) state_n = NEXT;
      NEXT: if (retired == len || halt_lat) begin
        state_n = DONE;
      end else begin
        advance = 1'b1;
        state_n = FETCH;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= START_PC;
      retired     <= 16'd0;
      len         <= 16'd0;
      halt_lat    <= 1'b0;
      timer       <= '0;
      dec_data    <= 32'd0;
      dec_dir     <= 1'b0;
      res_ack     <= 1'b0;
      last_result <= 32'd0;
      error       <= 1'b0;
    end else begin
      if (load_run) begin
        pc       <= START_PC;
        retired  <= 16'd0;
        len      <= prog_len;
        halt_lat <= 1'b0;
        error    <= 1'b0;
      end else if (busy && halt) begin
        halt_lat <= 1'b1;
      end
      if (take_instr) begin
        dec_data <= mem_data;
        dec_dir  <= 1'b1;
      end
      if (sent) begin
        dec_dir <= 1'b0;
        timer   <= '0;
      end else if (state == WAIT_RESULT) begin
        timer <= timer + 1'b1;
      end
      if (capture) begin
        last_result <= res_data;
        retired     <= retired + 16'd1;
      end
      res_ack <= capture;
      if (timeout) error <= 1'b1;
      if (advance) pc <= pc + 1'b1;
    end
  end

  assign mem_addr = pc;
  assign mem_rd   = (state == FETCH);
  assign busy     = (state != IDLE) && (state != ERROR);
  assign done     = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// Bench for instruction_sequencer: memory/decoder responder plus result and address scoreboards.
module tb_instruction_sequencer;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, halt = 1'b0;
  logic [15:0] prog_len = 16'd0;
  logic [31:0] mem_data = 32'd0, res_data = 32'd0;
  logic        mem_valid = 1'b0, dec_ack = 1'b0, res_dor = 1'b0;

  logic [7:0]  addr_a, pc_a;
  logic [1:0]  addr_b, pc_b;
  logic [31:0] dd_a, dd_b, lr_a, lr_b;
  logic [15:0] ret_a, ret_b;
  logic        rd_a, rd_b, dir_a, dir_b, ra_a, ra_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

  instruction_sequencer #(.ADDR_WIDTH(8), .START_ADDR(0), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .prog_len(prog_len), .halt(halt),
    .mem_addr(addr_a), .mem_rd(rd_a), .mem_data(mem_data), .mem_valid(mem_valid),
    .dec_data(dd_a), .dec_dir(dir_a), .dec_ack(dec_ack), .res_data(res_data),
    .res_dor(res_dor), .res_ack(ra_a), .pc(pc_a), .retired(ret_a), .last_result(lr_a),
    .busy(busy_a), .done(done_a), .error(err_a));

  instruction_sequencer #(.ADDR_WIDTH(2), .START_ADDR(3), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .prog_len(prog_len), .halt(halt),
    .mem_addr(addr_b), .mem_rd(rd_b), .mem_data(mem_data), .mem_valid(mem_valid),
    .dec_data(dd_b), .dec_dir(dir_b), .dec_ack(dec_ack), .res_data(res_data),
    .res_dor(res_dor), .res_ack(ra_b), .pc(pc_b), .retired(ret_b), .last_result(lr_b),
    .busy(busy_b), .done(done_b), .error(err_b));

  // The responder serves whichever instance is selected.
  logic       sel = 1'b0;
  logic       m_rd, m_dir, m_rack, m_done, m_err;
  logic [7:0] m_addr;
  assign m_rd   = sel ? rd_b   : rd_a;
  assign m_dir  = sel ? dir_b  : dir_a;
  assign m_rack = sel ? ra_b   : ra_a;
  assign m_done = sel ? done_b : done_a;
  assign m_err  = sel ? err_b  : err_a;
  assign m_addr = sel ? {6'd0, addr_b} : addr_a;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, rd_cycles = 0, wait_enter = 0, err_cyc = 0;
  int dstate = 0, ack_cnt = 0, exec_cnt = 0, rd_cnt = 0;
  int ack_delay = 0, exec_delay = 1;
  bit nores = 1'b0, prev_ack = 1'b0, prev_dir = 1'b0, prev_rack = 1'b0, prev_err = 1'b0;
  logic [31:0] mem_a [256];
  logic [31:0] res_q[$], exp_res[$];
  logic [7:0]  exp_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      dstate = 0; ack_cnt = 0; exec_cnt = 0; rd_cnt = 0;
      dec_ack = 1'b0; res_dor = 1'b0; mem_valid = 1'b0;
      prev_ack = 1'b0; prev_dir = 1'b0; prev_rack = 1'b0; prev_err = 1'b0;
    end else begin
      if (m_done) done_cnt++;
      if (prev_ack && prev_dir) begin
        chk("dir_drop", {31'd0, m_dir}, 32'd0);
        wait_enter = cyc;
      end
      if (prev_rack) chk("res_ack_pulse", {31'd0, m_rack}, 32'd0);
      if (m_rack && !prev_rack) begin
        if (exp_res.size() == 0) chk("result_unexpected", 32'd1, 32'd0);
        else chk("result", sel ? lr_b : lr_a, exp_res.pop_front());
      end
      if (m_err && !prev_err) err_cyc = cyc;
      if (m_rd) rd_cycles++;
      // Memory answers one cycle after the request appears.
      if (m_rd && !mem_valid) begin
        if (rd_cnt == 1) begin
          if (exp_addr.size() == 0) chk("mem_addr_unexpected", 32'd1, 32'd0);
          else chk("mem_addr", {24'd0, m_addr}, {24'd0, exp_addr.pop_front()});
          mem_data  = mem_a[m_addr];
          mem_valid = 1'b1;
        end else rd_cnt++;
      end else if (!m_rd) begin
        mem_valid = 1'b0;
        rd_cnt    = 0;
      end
      case (dstate)
        0: if (m_dir) begin
          if (ack_cnt >= ack_delay) begin dec_ack = 1'b1; dstate = 1; end
          else ack_cnt++;
        end
        1: if (!m_dir) begin
          dec_ack = 1'b0; ack_cnt = 0; exec_cnt = 0;
          dstate  = nores ? 0 : 2;
        end
        2: if (exec_cnt >= exec_delay) begin
          res_data = (res_q.size() != 0) ? res_q.pop_front() : 32'hDEAD_BEEF;
          res_dor  = 1'b1;
          dstate   = 3;
        end else exec_cnt++;
        default: if (m_rack) begin res_dor = 1'b0; dstate = 0; end
      endcase
      prev_ack  = dec_ack;
      prev_dir  = m_dir;
      prev_rack = m_rack;
      prev_err  = m_err;
    end
  end

  task automatic do_start(input bit b, input logic [15:0] len);
    @(negedge clk);
    prog_len = len;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    int d0 = done_cnt;
    while (!m_done && i < budget) begin @(negedge clk); i++; end
    chk(tag, {31'd0, m_done}, 32'd1);
    @(negedge clk);
    chk({tag, "_one_pulse"}, done_cnt - d0, 32'd1);
    chk({tag, "_busy_after"}, {31'd0, sel ? busy_b : busy_a}, 32'd0);
  endtask

  initial begin
    int i;
    int rd0;
    for (int k = 0; k < 256; k++) mem_a[k] = 32'h1000_0000 + k;

    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'd0, busy_a}, 32'd0);
    chk("rst_mem_rd", {31'd0, rd_a}, 32'd0);
    chk("rst_dir",   {31'd0, dir_a}, 32'd0);
    chk("rst_err",   {31'd0, err_a}, 32'd0);
    chk("rst_pc",    {24'd0, pc_a}, 32'd0);
    chk("rst_pc_b",  {30'd0, pc_b}, 32'd3);
    chk("rst_lr",    lr_a, 32'd0);
    reset_n = 1'b1;

    // Single instruction
    mem_a[0] = 32'h012A4020;
    res_q.push_back(32'd7); exp_res.push_back(32'd7); exp_addr.push_back(8'd0);
    do_start(1'b0, 16'd1);
    wait_done("single_done", 40);
    chk("single_retired", {16'd0, ret_a}, 32'd1);
    chk("single_pc", {24'd0, pc_a}, 32'd0);
    chk("single_dec_data", dd_a, 32'h012A4020);

    // Three instructions
    foreach (res_q[k]) ;
    res_q = '{32'd5, 32'd9, 32'd14}; exp_res = '{32'd5, 32'd9, 32'd14};
    exp_addr = '{8'd0, 8'd1, 8'd2};
    do_start(1'b0, 16'd3);
    wait_done("three_done", 100);
    chk("three_retired", {16'd0, ret_a}, 32'd3);
    chk("three_last", lr_a, 32'd14);
    chk("three_pc", {24'd0, pc_a}, 32'd2);
    chk("three_addr_left", exp_addr.size(), 32'd0);

    // Watchdog
    nores = 1'b1; exp_addr.push_back(8'd0);
    do_start(1'b0, 16'd1);
    i = 0;
    while (!err_a && i < 60) begin @(negedge clk); i++; end
    @(negedge clk);
    chk("wd_error", {31'd0, err_a}, 32'd1);
    chk("wd_latency", err_cyc - wait_enter, 32'd8);
    chk("wd_busy", {31'd0, busy_a}, 32'd0);
    chk("wd_pc", {24'd0, pc_a}, 32'd0);
    nores = 1'b0;
    res_q.push_back(32'd21); exp_res.push_back(32'd21); exp_addr.push_back(8'd0);
    do_start(1'b0, 16'd1);
    chk("wd_cleared", {31'd0, err_a}, 32'd0);
    wait_done("wd_restart_done", 40);
    chk("wd_restart_retired", {16'd0, ret_a}, 32'd1);

    // Halt during the third instruction's result wait
    exec_delay = 3;
    for (int k = 0; k < 10; k++) res_q.push_back(32'd50 + k);
    exp_res = '{32'd50, 32'd51, 32'd52}; exp_addr = '{8'd0, 8'd1, 8'd2};
    do_start(1'b0, 16'd10);
    i = 0;
    while (!(ret_a == 16'd2 && dstate == 2) && i < 200) begin @(negedge clk); i++; end
    chk("halt_window", {31'd0, (ret_a == 16'd2)}, 32'd1);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    wait_done("halt_done", 60);
    chk("halt_retired", {16'd0, ret_a}, 32'd3);
    rd0 = rd_cycles;
    repeat (5) @(negedge clk);
    chk("halt_no_fetch", rd_cycles - rd0, 32'd0);
    chk("halt_addr_left", exp_addr.size(), 32'd0);
    res_q.delete();
    exec_delay = 1;

    // Wrap on the 2-bit instance
    sel = 1'b1;
    mem_a[3] = 32'hAAAA_0003; mem_a[0] = 32'hAAAA_0000;
    res_q = '{32'd100, 32'd200}; exp_res = '{32'd100, 32'd200};
    exp_addr = '{8'd3, 8'd0};
    do_start(1'b1, 16'd2);
    wait_done("wrap_done", 80);
    chk("wrap_retired", {16'd0, ret_b}, 32'd2);
    chk("wrap_pc", {30'd0, pc_b}, 32'd0);
    chk("wrap_addr_left", exp_addr.size(), 32'd0);
    sel = 1'b0;

    // Empty program
    @(negedge clk);
    rd0 = rd_cycles;
    do_start(1'b0, 16'd0);
    chk("empty_done", {31'd0, done_a}, 32'd1);
    @(negedge clk);
    chk("empty_done_low", {31'd0, done_a}, 32'd0);
    chk("empty_no_rd", rd_cycles - rd0, 32'd0);

    // Asynchronous reset while in SEND
    ack_delay = 4;
    res_q.push_back(32'd33); exp_addr.push_back(8'd0);
    do_start(1'b0, 16'd1);
    i = 0;
    while (!dir_a && i < 40) begin @(negedge clk); i++; end
    chk("ar_in_send", {31'd0, dir_a}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_dir",  {31'd0, dir_a}, 32'd0);
    chk("ar_rack", {31'd0, ra_a}, 32'd0);
    chk("ar_busy", {31'd0, busy_a}, 32'd0);
    chk("ar_err",  {31'd0, err_a}, 32'd0);
    res_q.delete(); exp_res.delete(); exp_addr.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ar_idle_busy", {31'd0, busy_a}, 32'd0);
    chk("ar_idle_rd", {31'd0, rd_a}, 32'd0);
    chk("ar_retired", {16'd0, ret_a}, 32'd0);
    ack_delay = 0;
    res_q.push_back(32'd44); exp_res.push_back(32'd44); exp_addr.push_back(8'd0);
    do_start(1'b0, 16'd1);
    wait_done("ar_rerun_done", 40);
    chk("ar_rerun_last", lr_a, 32'd44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
